// File: rtl/bcd_scroll_source.sv
// bcd_scroll_source: three-digit up/down BCD event counter driven by three debounced buttons.
// Feeds hundreds/tens/ones digits plus a one-cycle update strobe to the scrolling display.
module bcd_scroll_source #(
  parameter int TICK_DIV   = 1000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_run,
  input  logic       btn_dir,
  input  logic       btn_clr,
  output logic [3:0] digit_a,
  output logic [3:0] digit_b,
  output logic [3:0] digit_c,
  output logic       upd,
  output logic       running,
  output logic       dir_down
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {STOP, RUN, CLR} state_e;
  state_e state_q, state_d;
  logic [2:0] btn, s1_q, s2_q, lvl_q, lvl_d, prev_q, press_q;
  logic [TW-1:0] div_q, div_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic dir_q, dir_d, upd_q, upd_d, tick, clr_go, cy_c, cy_b;

  function automatic logic [3:0] nxt(input logic [3:0] v, input logic dn);
    return dn ? (v == 4'd0 ? 4'd9 : v - 4'd1) : (v == 4'd9 ? 4'd0 : v + 4'd1);
  endfunction

  function automatic logic lim(input logic [3:0] v, input logic dn);
    return v == (dn ? 4'd0 : 4'd9);
  endfunction

  assign btn = {btn_clr, btn_dir, btn_run};

  // A new level is accepted only after DEB_CYCLES consecutive disagreeing samples
  for (genvar b = 0; b < 3; b++) begin : g_deb
    logic [DW-1:0] cnt_q, cnt_d;
    logic diff, hit;
    assign diff = s2_q[b] ^ lvl_q[b];
    assign hit = diff && cnt_q == DW'(DEB_CYCLES - 1);
    assign cnt_d = (diff && !hit) ? cnt_q + 1'b1 : '0;
    assign lvl_d[b] = hit ? s2_q[b] : lvl_q[b];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
  end

  always_comb begin
    state_d = state_q == CLR ? STOP :
              press_q[2]     ? CLR :
              press_q[0]     ? (state_q == RUN ? STOP : RUN) : state_q;
  end

  // Clear beats a coincident tick; divider restarts whenever RUN is (re)entered
  assign tick   = state_q == RUN && div_q == TW'(TICK_DIV - 1);
  assign clr_go = state_d == CLR;
  assign div_d  = (tick || state_q != RUN || state_d != RUN) ? '0 : div_q + 1'b1;
  assign cy_c   = lim(c_q, dir_q);
  assign cy_b   = cy_c && lim(b_q, dir_q);
  assign c_d    = clr_go ? '0 : tick ? nxt(c_q, dir_q) : c_q;
  assign b_d    = clr_go ? '0 : tick && cy_c ? nxt(b_q, dir_q) : b_q;
  assign a_d    = clr_go ? '0 : tick && cy_b ? nxt(a_q, dir_q) : a_q;
  assign upd_d  = clr_go ? |{a_q, b_q, c_q} : tick;
  assign dir_d  = dir_q ^ press_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      press_q <= '0;
      state_q <= STOP;
      div_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      dir_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      press_q <= lvl_q & ~prev_q;
      state_q <= state_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      dir_q   <= dir_d;
      upd_q   <= upd_d;
    end
  end

  assign digit_a  = a_q;
  assign digit_b  = b_q;
  assign digit_c  = c_q;
  assign upd      = upd_q;
  assign running  = state_q == RUN;
  assign dir_down = dir_q;
endmodule

// File: tb/tb_bcd_scroll_source.sv
// tb_bcd_scroll_source: scenario tasks checked against an integer-count model of the counter.
module tb_bcd_scroll_source;
  localparam int TICK = 4, DEB = 3, PL = 11;
  logic clk = 1'b0, rst_n = 1'b0, btn_run = 1'b0, btn_dir = 1'b0, btn_clr = 1'b0;
  logic [3:0] digit_a, digit_b, digit_c;
  logic upd, running, dir_down;
  int checks = 0, errors = 0, upd_seen = 0, m_upd = 0, m_val = 0, m_ph = 0;
  bit m_run = 1'b0, m_dn = 1'b0;
  wire [13:0] obs = {digit_a, digit_b, digit_c, running, dir_down};

  bcd_scroll_source #(.TICK_DIV(TICK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_run(btn_run), .btn_dir(btn_dir), .btn_clr(btn_clr),
    .digit_a(digit_a), .digit_b(digit_b), .digit_c(digit_c),
    .upd(upd), .running(running), .dir_down(dir_down)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (upd === 1'b1) upd_seen++;

  function automatic int stepv(input int v, input bit dn);
    return dn ? (v + 999) % 1000 : (v + 1) % 1000;
  endfunction

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] expv();
    return {bcd(m_val), m_run, m_dn};
  endfunction

  // Advance n cycles; while running, a step lands every TICK cycles after running rose
  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      if (m_run) begin
        m_ph++;
        if (m_ph % TICK == 0) begin
          m_val = stepv(m_val, m_dn);
          m_upd++;
        end
      end
    end
  endtask

  // Clean press: 4 idle cycles, 5 cycles held, effect on the 7th edge after the raw rise
  task automatic press(input bit r, input bit d, input bit c);
    bit t;
    adv(4);
    btn_run = r; btn_dir = d; btn_clr = c;
    adv(5);
    btn_run = 1'b0; btn_dir = 1'b0; btn_clr = 1'b0;
    adv(1);
    @(negedge clk); #1;
    t = m_run && ((m_ph + 1) % TICK == 0);
    if (c) begin
      if (m_val != 0) m_upd++;
      m_val = 0;
      m_run = 1'b0;
    end else begin
      if (t) begin
        m_val = stepv(m_val, m_dn);
        m_upd++;
      end
      if (r) begin
        m_run = !m_run;
        m_ph = 0;
      end else if (m_run) m_ph++;
    end
    if (d) m_dn = !m_dn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs !== 14'd0 || upd !== 1'b0) begin
      errors++; $display("FAIL reset_values: got %h upd %b, expected 0000 upd 0", obs, upd);
    end
    rst_n = 1'b1;
    adv(12);
    checks++;
    if (obs !== expv() || upd_seen !== m_upd) begin
      errors++; $display("FAIL idle_after_reset: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), m_upd);
    end
  endtask

  task automatic test_run_count();
    int u0;
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL run_start: running %b, expected 1", running);
    end
    u0 = upd_seen;
    adv(40);
    checks++;
    if (obs !== {12'h010, 1'b1, 1'b0} || upd_seen - u0 !== 10) begin
      errors++; $display("FAIL run_40_cycles: got %h with %0d upd, expected %h with 10 upd", obs, upd_seen - u0, {12'h010, 1'b1, 1'b0});
    end
    adv($urandom_range(1, 30));
    checks++;
    if (obs !== expv() || upd_seen !== m_upd) begin
      errors++; $display("FAIL run_random: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), m_upd);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 5000 && m_val != 57; i++) adv(1);
    checks++;
    if (obs !== {12'h057, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reach_057: got %h, expected %h", obs, {12'h057, 1'b1, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 14'd0 || upd !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h upd %b, expected 0000 upd 0", obs, upd);
    end
    m_val = 0; m_run = 1'b0; m_dn = 1'b0; m_ph = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    adv(20);
    checks++;
    if (obs !== expv() || upd_seen !== m_upd) begin
      errors++; $display("FAIL no_step_after_reset: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), m_upd);
    end
  endtask

  task automatic test_down();
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {12'h000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL dir_toggle: got %h, expected %h", obs, {12'h000, 1'b0, 1'b1});
    end
    press(1'b1, 1'b0, 1'b0);
    adv(4);
    checks++;
    if (obs !== {12'h999, 1'b1, 1'b1}) begin
      errors++; $display("FAIL down_to_999: got %h, expected %h", obs, {12'h999, 1'b1, 1'b1});
    end
    adv(4);
    checks++;
    if (obs !== {12'h998, 1'b1, 1'b1}) begin
      errors++; $display("FAIL down_to_998: got %h, expected %h", obs, {12'h998, 1'b1, 1'b1});
    end
  endtask

  task automatic test_wrap();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5000 && m_val != 998; i++) adv(1);
    adv(4);
    checks++;
    if (obs !== {12'h999, 1'b1, 1'b0}) begin
      errors++; $display("FAIL up_to_999: got %h, expected %h", obs, {12'h999, 1'b1, 1'b0});
    end
    adv(4);
    checks++;
    if (obs !== {12'h000, 1'b1, 1'b0} || upd_seen !== m_upd) begin
      errors++; $display("FAIL wrap_to_000: got %h/%0d, expected %h/%0d", obs, upd_seen, {12'h000, 1'b1, 1'b0}, m_upd);
    end
  endtask

  task automatic test_dir_tick();
    int v0;
    for (int i = 0; i < 8 && (m_ph + PL) % TICK != 0; i++) adv(1);
    v0 = m_val;
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== {bcd((v0 + 3) % 1000), 1'b1, 1'b1}) begin
      errors++; $display("FAIL dir_with_tick: got %h, expected %h", obs, {bcd((v0 + 3) % 1000), 1'b1, 1'b1});
    end
    adv(4);
    checks++;
    if (obs !== {bcd((v0 + 2) % 1000), 1'b1, 1'b1}) begin
      errors++; $display("FAIL dir_next_tick: got %h, expected %h", obs, {bcd((v0 + 2) % 1000), 1'b1, 1'b1});
    end
  endtask

  task automatic test_debounce();
    press(1'b1, 1'b0, 1'b0);
    adv(4);
    btn_run = 1'b1;
    adv($urandom_range(1, DEB - 1));
    btn_run = 1'b0;
    adv(12);
    checks++;
    if (obs !== expv() || running !== 1'b0) begin
      errors++; $display("FAIL glitch_ignored: got %h, expected %h", obs, expv());
    end
    btn_run = 1'b1;
    adv(5);
    btn_run = 1'b0;
    adv(1);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL press_latency_early: running %b at 6 cycles, expected 0", running);
    end
    adv(1);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL press_latency: running %b at 7 cycles, expected 1", running);
    end
    m_run = 1'b1; m_ph = 0;
    adv(12);
    checks++;
    if (obs !== expv() || upd_seen !== m_upd) begin
      errors++; $display("FAIL release_no_toggle: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), m_upd);
    end
  endtask

  task automatic test_clear_priority();
    int u0;
    for (int i = 0; i < 8000 && !((m_ph + PL) % TICK == 0 && stepv(stepv(m_val, m_dn), m_dn) == 123); i++) adv(1);
    u0 = upd_seen;
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== {12'h000, 1'b0, m_dn} || upd_seen - u0 !== 3) begin
      errors++; $display("FAIL clr_run_tick_at_123: got %h with %0d upd, expected %h with 3 upd", obs, upd_seen - u0, {12'h000, 1'b0, m_dn});
    end
    adv(4);
    checks++;
    if (obs !== expv() || upd_seen !== m_upd) begin
      errors++; $display("FAIL stop_after_clr: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), m_upd);
    end
    u0 = upd_seen;
    press(1'b0, 1'b0, 1'b1);
    adv(2);
    checks++;
    if (obs !== expv() || upd_seen !== u0) begin
      errors++; $display("FAIL clr_at_000_no_upd: got %h/%0d, expected %h/%0d", obs, upd_seen, expv(), u0);
    end
  endtask

  task automatic test_pause();
    int v0, e;
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8 && (m_ph + PL) % TICK != 0; i++) adv(1);
    v0 = m_val;
    e = stepv(stepv(stepv(v0, m_dn), m_dn), m_dn);
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== {bcd(e), 1'b0, m_dn}) begin
      errors++; $display("FAIL pause_with_tick: got %h, expected %h", obs, {bcd(e), 1'b0, m_dn});
    end
    adv($urandom_range(5, 25));
    checks++;
    if (obs !== {bcd(e), 1'b0, m_dn}) begin
      errors++; $display("FAIL pause_frozen: got %h, expected %h", obs, {bcd(e), 1'b0, m_dn});
    end
    press(1'b1, 1'b0, 1'b0);
    adv(TICK - 1);
    checks++;
    if (obs !== {bcd(e), 1'b1, m_dn}) begin
      errors++; $display("FAIL rerun_no_early_step: got %h, expected %h", obs, {bcd(e), 1'b1, m_dn});
    end
    adv(1);
    checks++;
    if (obs !== {bcd(stepv(e, m_dn)), 1'b1, m_dn}) begin
      errors++; $display("FAIL rerun_first_step: got %h, expected %h", obs, {bcd(stepv(e, m_dn)), 1'b1, m_dn});
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] mask;
    for (int i = 0; i < 16; i++) begin
      mask = 3'($urandom_range(1, 7));
      press(mask[0], mask[1], mask[2]);
      checks++;
      if (obs !== expv() || upd_seen !== m_upd) begin
        errors++; $display("FAIL b2b_press[%0d] mask %b: got %h/%0d, expected %h/%0d", i, mask, obs, upd_seen, expv(), m_upd);
      end
      adv($urandom_range(0, 10));
      checks++;
      if (obs !== expv() || upd_seen !== m_upd) begin
        errors++; $display("FAIL b2b_gap[%0d]: got %h/%0d, expected %h/%0d", i, obs, upd_seen, expv(), m_upd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_reset_mid_run();
    test_down();
    test_wrap();
    test_dir_tick();
    test_debounce();
    test_clear_priority();
    test_pause();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
